// File: rtl/pif_led_pkg.sv
// pif_led_pkg: shared fader state encoding and default parameters
package pif_led_pkg;

    typedef enum logic [1:0] {
        FADE_OFF = 2'd0,
        FADE_UP  = 2'd1,
        FADE_ON  = 2'd2,
        FADE_DN  = 2'd3
    } fade_e;

    localparam int DEF_PWM_BITS  = 8;
    localparam int DEF_RAMP_DIV  = 4;
    localparam int DEF_RAMP_STEP = 8;

endpackage

// File: rtl/pif_fade_chan.sv
// pif_fade_chan: one LED channel with level register, fade FSM, duty registers and PWM comparator
module pif_fade_chan
    import pif_led_pkg::*;
#(
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lvl_in,
    input  logic                pb,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] maxd,
    input  logic [PWM_BITS-1:0] pcnt,
    output logic                pwm,
    output logic                busy
);

    localparam logic [PWM_BITS:0] STEP = (PWM_BITS + 1)'(RAMP_STEP);

    fade_e               st, st_n;
    logic                lvl;
    logic [PWM_BITS-1:0] duty, duty_n, duty_act, up, dn;
    logic [PWM_BITS:0]   sum;

    assign sum = {1'b0, duty} + STEP;
    assign up  = sum > {1'b0, maxd} ? maxd : sum[PWM_BITS-1:0];
    assign dn  = {1'b0, duty} > STEP ? duty - STEP[PWM_BITS-1:0] : '0;

    // next state and duty target; a level change wins over a coincident ramp tick
    always_comb begin
        st_n   = st;
        duty_n = duty;
        case (st)
            FADE_OFF: st_n = lvl ? FADE_UP : FADE_OFF;
            FADE_UP: begin
                if (!lvl) st_n = FADE_DN;
                else if (tick) begin
                    duty_n = up;
                    st_n   = up == maxd ? FADE_ON : FADE_UP;
                end
            end
            FADE_ON: begin
                if (!lvl) st_n = FADE_DN;
                else if (pb) duty_n = maxd;
            end
            FADE_DN: begin
                if (lvl) st_n = FADE_UP;
                else if (tick) begin
                    duty_n = dn;
                    st_n   = dn == '0 ? FADE_OFF : FADE_DN;
                end
            end
            default: st_n = FADE_OFF;
        endcase
    end

    // state, duty and registered outputs; active duty only reloads at a period boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl      <= 1'b0;
            st       <= FADE_OFF;
            duty     <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            lvl      <= lvl_in;
            st       <= st_n;
            duty     <= duty_n;
            duty_act <= pb ? duty_n : duty_act;
            pwm      <= pcnt < duty_act;
            busy     <= st_n == FADE_UP || st_n == FADE_DN;
        end
    end

endmodule

// File: rtl/pif_led_fader.sv
// pif_led_fader: two-channel LED PWM fader with shared period counter, ramp divider and brightness ceiling
module pif_led_fader
    import pif_led_pkg::*;
#(
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int RAMP_DIV  = DEF_RAMP_DIV,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic                xclk,
    input  logic                sys_rst,
    input  logic                red_in,
    input  logic                green_in,
    input  logic [PWM_BITS-1:0] max_duty,
    output logic                red_pwm,
    output logic                green_pwm,
    output logic                red_busy,
    output logic                green_busy
);

    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

    logic [PWM_BITS-1:0] pcnt, maxd, maxd_eff;
    logic [7:0]          div;
    logic                pb, tick;

    assign pb       = &pcnt;
    assign tick     = pb && div == DIV_LAST;
    assign maxd_eff = pb ? max_duty : maxd;

    // free-running PWM counter, ramp divider counting period boundaries, ceiling latch
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            pcnt <= '0;
            div  <= '0;
            maxd <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
            maxd <= pb ? max_duty : maxd;
            div  <= !pb ? div : div == DIV_LAST ? 8'd0 : div + 8'd1;
        end
    end

    pif_fade_chan #(
        .PWM_BITS  (PWM_BITS),
        .RAMP_STEP (RAMP_STEP)
    ) u_red (
        .clk    (xclk),
        .rst    (sys_rst),
        .lvl_in (red_in),
        .pb     (pb),
        .tick   (tick),
        .maxd   (maxd_eff),
        .pcnt   (pcnt),
        .pwm    (red_pwm),
        .busy   (red_busy)
    );

    pif_fade_chan #(
        .PWM_BITS  (PWM_BITS),
        .RAMP_STEP (RAMP_STEP)
    ) u_green (
        .clk    (xclk),
        .rst    (sys_rst),
        .lvl_in (green_in),
        .pb     (pb),
        .tick   (tick),
        .maxd   (maxd_eff),
        .pcnt   (pcnt),
        .pwm    (green_pwm),
        .busy   (green_busy)
    );

endmodule

// File: tb/tb_pif_led_fader.sv
// tb_pif_led_fader: directed and randomized checks of the LED fader against a behavioural model
module tb_pif_led_fader;

    localparam int PER = 16;
    localparam int RD  = 2;
    localparam int RS  = 4;

    logic       xclk = 1'b0;
    logic       sys_rst, red_in, green_in;
    logic [3:0] max_duty;
    logic       red_pwm, green_pwm, red_busy, green_busy;

    int vectors = 0, miscompares = 0;
    int armed = 0;

    int cyc, periods, m, p, pbm, tk, mn;
    int duty[2], dact[2], follow[2], settled[2], lvl[2], mpwm[2], mbusy[2];

    int q[$], r[$];

    pif_led_fader #(
        .PWM_BITS  (4),
        .RAMP_DIV  (2),
        .RAMP_STEP (4)
    ) dut (
        .xclk       (xclk),
        .sys_rst    (sys_rst),
        .red_in     (red_in),
        .green_in   (green_in),
        .max_duty   (max_duty),
        .red_pwm    (red_pwm),
        .green_pwm  (green_pwm),
        .red_busy   (red_busy),
        .green_busy (green_busy)
    );

    always #5 xclk = ~xclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel follows its delayed level; when the followed level
    // changes the channel becomes unsettled, then every ramp tick moves duty one step
    // toward its goal (ceiling or zero) until it arrives; a settled lit channel copies the ceiling.
    always @(posedge xclk) begin
        if (sys_rst) begin
            cyc = 0;
            periods = 0;
            m = 0;
            for (int c = 0; c < 2; c++) begin
                duty[c] = 0; dact[c] = 0; follow[c] = 0; settled[c] = 1;
                lvl[c] = 0; mpwm[c] = 0; mbusy[c] = 0;
            end
        end else begin
            p   = cyc % PER;
            pbm = (p == PER - 1) ? 1 : 0;
            tk  = (pbm != 0 && periods % RD == RD - 1) ? 1 : 0;
            mn  = pbm != 0 ? int'(max_duty) : m;
            for (int c = 0; c < 2; c++) begin
                mpwm[c] = p < dact[c] ? 1 : 0;
                if (lvl[c] != follow[c]) begin
                    follow[c]  = lvl[c];
                    settled[c] = 0;
                end else if (settled[c] == 0 && tk != 0) begin
                    if (follow[c] != 0) duty[c] = duty[c] + RS < mn ? duty[c] + RS : mn;
                    else duty[c] = duty[c] > RS ? duty[c] - RS : 0;
                    settled[c] = duty[c] == (follow[c] != 0 ? mn : 0) ? 1 : 0;
                end else if (settled[c] != 0 && follow[c] != 0 && pbm != 0) begin
                    duty[c] = mn;
                end
                if (pbm != 0) dact[c] = duty[c];
                mbusy[c] = settled[c] != 0 ? 0 : 1;
            end
            lvl[0] = int'(red_in);
            lvl[1] = int'(green_in);
            if (pbm != 0) begin
                m = int'(max_duty);
                periods++;
            end
            cyc++;
        end
    end

    always @(negedge xclk) begin
        if (armed != 0) begin
            chk("red_pwm", red_pwm, mpwm[0]);
            chk("green_pwm", green_pwm, mpwm[1]);
            chk("red_busy", red_busy, mbusy[0]);
            chk("green_busy", green_busy, mbusy[1]);
        end
    end

    // count pwm-high cycles over one full period; inj 1 lowers max_duty mid-period, inj 2 drops red at the tick
    task automatic measure(input int ch, input int inj, output int n);
        while (cyc % PER != 1) @(negedge xclk);
        n = 0;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge xclk);
            n += int'(ch != 0 ? green_pwm : red_pwm);
            if (i == 7 && inj == 1) max_duty = 4'd6;
            if (i == 13 && inj == 2) red_in = 1'b0;
        end
    endtask

    task automatic runs(input int ch, input int nw, input int drop0);
        int n;
        q.delete();
        r.delete();
        for (int i = 0; i < nw; i++) begin
            measure(ch, 0, n);
            if (q.size() == 0 || q[q.size()-1] != n) begin
                q.push_back(n);
                r.push_back(1);
            end else r[r.size()-1]++;
        end
        if (drop0 != 0 && q.size() > 0 && q[0] == 0) begin
            void'(q.pop_front());
            void'(r.pop_front());
        end
    endtask

    function automatic int qat(input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    function automatic int rat(input int i);
        return i < r.size() ? r[i] : -1;
    endfunction

    task automatic wait_idle();
        int k;
        repeat (4) @(negedge xclk);
        k = 0;
        while ((red_busy || green_busy) && k < 3000) begin
            @(negedge xclk);
            k++;
        end
        chk("idle_within_bound", k < 3000 ? 1 : 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int k, n, prev, a, b;
        int eu[4] = '{4, 8, 12, 15};
        int ed[3] = '{8, 4, 0};
        sys_rst = 1'b1; red_in = 1'b1; green_in = 1'b1; max_duty = 4'd15;
        @(negedge xclk);
        armed = 1;
        repeat (4) @(negedge xclk);
        chk("reset_red_pwm", red_pwm, 0);
        chk("reset_green_pwm", green_pwm, 0);
        chk("reset_red_busy", red_busy, 0);
        chk("reset_green_busy", green_busy, 0);
        sys_rst = 1'b0;
        k = 0;
        while (!red_pwm && k < 200) begin
            @(negedge xclk);
            k++;
        end
        chk("first_pwm_not_before_tick", (k >= 32 && k < 200) ? 1 : 0, 1);

        red_in = 1'b0; green_in = 1'b0;
        wait_idle();
        red_in = 1'b1;
        runs(0, 12, 1);
        chk("ramp_up_steps", q.size(), 4);
        for (int i = 0; i < 4; i++) chk("ramp_up_duty", qat(i), eu[i]);
        for (int i = 0; i < 3; i++) chk("ramp_up_hold_periods", rat(i), 2);
        chk("ramp_up_done_busy", red_busy, 0);

        red_in = 1'b0;
        wait_idle();
        red_in = 1'b1;
        prev = -1; n = -1;
        for (int j = 0; j < 20 && !(n == 8 && prev != 8); j++) begin
            prev = n;
            measure(0, 0, n);
        end
        chk("found_duty8", n, 8);
        red_in = 1'b0;
        runs(0, 6, 0);
        chk("ramp_down_steps", q.size(), 3);
        for (int i = 0; i < 3; i++) chk("ramp_down_duty", qat(i), ed[i]);
        chk("ramp_down_hold_periods", rat(1), 2);
        chk("ramp_down_done_busy", red_busy, 0);

        green_in = 1'b1;
        wait_idle();
        measure(1, 1, a);
        chk("ceiling_change_no_truncation", a, 15);
        measure(1, 0, b);
        chk("ceiling_change_new_duty", b, 6);
        chk("ceiling_change_no_ramp", green_busy, 0);
        max_duty = 4'd15;

        red_in = 1'b1;
        n = -1;
        for (int j = 0; j < 20 && n != 4; j++) measure(0, 0, n);
        chk("found_duty4", n, 4);
        for (int j = 0; j < 3; j++) begin
            while (cyc % PER != 1) @(negedge xclk);
            if (periods % RD == RD - 1) break;
            @(negedge xclk);
        end
        measure(0, 2, a);
        chk("toggle_window", a, 4);
        measure(0, 0, b);
        chk("tick_step_dropped", b, 4);
        chk("toggle_reversed_busy", red_busy, 1);
        measure(0, 0, b);
        chk("toggle_hold", b, 4);
        measure(0, 0, b);
        chk("toggle_ramp_down_end", b, 0);
        chk("toggle_off_busy", red_busy, 0);

        max_duty = 4'd0;
        red_in = 1'b1;
        for (int j = 0; j < 4; j++) measure(0, 0, n);
        chk("maxd0_pwm", n, 0);
        chk("maxd0_on_busy", red_busy, 0);
        max_duty = 4'd15;
        measure(0, 0, n);
        measure(0, 0, n);
        chk("on_tracks_ceiling", n, 15);
        chk("on_tracks_no_ramp", red_busy, 0);

        red_in = 1'b0; green_in = 1'b0;
        wait_idle();
        red_in = 1'b1; green_in = 1'b1;
        repeat (40) @(negedge xclk);
        chk("midramp_red_busy", red_busy, 1);
        chk("midramp_green_busy", green_busy, 1);
        sys_rst = 1'b1;
        @(negedge xclk);
        sys_rst = 1'b0;
        chk("midreset_red_pwm", red_pwm, 0);
        chk("midreset_green_pwm", green_pwm, 0);
        chk("midreset_red_busy", red_busy, 0);
        chk("midreset_green_busy", green_busy, 0);

        for (int i = 0; i < 6000; i++) begin
            @(negedge xclk);
            if ($urandom_range(59) == 0) red_in = ~red_in;
            if ($urandom_range(59) == 0) green_in = ~green_in;
            if ($urandom_range(199) == 0) max_duty = 4'($urandom_range(15));
            sys_rst = $urandom_range(1499) == 0;
        end
        sys_rst = 1'b0;
        repeat (4) @(negedge xclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
